// File: rtl/data_mem_responder_pkg.sv
// Shared CPU package: opcode/funct constants, data-memory FSM state
// encoding, wait-state counter width and the request-validity helper.
package data_mem_responder_pkg;

  localparam int WORD_W = 32;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_SLTI  = 6'h0a;
  localparam logic [5:0] OP_ANDI  = 6'h0c;
  localparam logic [5:0] OP_ORI   = 6'h0d;
  localparam logic [5:0] OP_LUI   = 6'h0f;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2b;

  localparam logic [5:0] FN_SLL   = 6'h00;
  localparam logic [5:0] FN_SRL   = 6'h02;
  localparam logic [5:0] FN_JR    = 6'h08;
  localparam logic [5:0] FN_ADD   = 6'h20;
  localparam logic [5:0] FN_SUB   = 6'h22;
  localparam logic [5:0] FN_AND   = 6'h24;
  localparam logic [5:0] FN_OR    = 6'h25;
  localparam logic [5:0] FN_XOR   = 6'h26;
  localparam logic [5:0] FN_NOR   = 6'h27;
  localparam logic [5:0] FN_SLT   = 6'h2a;

  // Wait-state counter holds 0..15.
  localparam int CNT_W = 4;

  typedef logic [CNT_W-1:0] wait_cnt_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    DONE = 2'd2
  } mem_state_t;

  // Exactly one of read/write, word aligned.
  function automatic logic req_valid(
    input logic       rd,
    input logic       wr,
    input logic [1:0] lsb
  );
    return (rd ^ wr) && (lsb == 2'b00);
  endfunction

endpackage

// File: rtl/data_mem_responder_ram.sv
// data_ram: single-port DEPTH x 32 array, synchronous write and read.
// Ports: clk, rst (clears read register only), we, re, idx, wdata, rdata.
module data_ram #(
  parameter int DEPTH = 256,
  parameter int IDX_W = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             we,
  input  logic             re,
  input  logic [IDX_W-1:0] idx,
  input  logic [31:0]      wdata,
  output logic [31:0]      rdata
);

  logic [31:0] mem [DEPTH];

  // Array contents survive reset.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[idx] <= wdata;
    end
  end

  // Read register holds until the next completed read.
  always_ff @(posedge clk) begin
    if (rst) begin
      rdata <= '0;
    end else if (re) begin
      rdata <= mem[idx];
    end
  end

endmodule

// File: rtl/data_mem_responder.sv
// data_mem_responder: wait-state data-memory FSM (IDLE/WAIT/DONE).
// Ports: clk, rst, MemRead, MemWrite, addr, wdata in; rdata, stall, ready, err out.
module data_mem_responder
  import data_mem_responder_pkg::*;
#(
  parameter int DEPTH       = 256,
  parameter int WAIT_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        MemRead,
  input  logic        MemWrite,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        stall,
  output logic        ready,
  output logic        err
);

  localparam int IDX_W = $clog2(DEPTH);

  mem_state_t       state;
  wait_cnt_t        cnt;

  logic             op_wr;
  logic [IDX_W-1:0] idx_q;
  logic [31:0]      wdata_q;

  logic             idle;
  logic             req_any;
  logic             req_ok;
  logic             req_bad;
  logic             go_done;
  logic             cur_wr;
  logic [IDX_W-1:0] req_idx;
  logic [IDX_W-1:0] cur_idx;
  logic [31:0]      cur_wdata;
  logic             ram_we;
  logic             ram_re;
  logic             unused_addr;

  assign idle    = (state == IDLE);
  assign req_any = MemRead | MemWrite;
  assign req_ok  = req_valid(MemRead, MemWrite, addr[1:0]);
  assign req_bad = req_any & ~req_ok;

  // High address bits are ignored so accesses wrap.
  assign req_idx     = addr[IDX_W+1:2];
  assign unused_addr = ^addr[31:IDX_W+2];

  assign stall = (idle & req_ok) | (state == WAIT);

  // With zero wait states the array is accessed on the accepting
  // edge, so the live request is used instead of the latch.
  assign go_done = ~rst & (
    (idle & req_ok & (WAIT_CYCLES == 0)) |
    ((state == WAIT) & (cnt == CNT_W'(1)))
  );

  assign cur_wr    = idle ? MemWrite : op_wr;
  assign cur_idx   = idle ? req_idx  : idx_q;
  assign cur_wdata = idle ? wdata    : wdata_q;

  assign ram_we = go_done & cur_wr;
  assign ram_re = go_done & ~cur_wr;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
      ready <= 1'b0;
      err   <= 1'b0;
    end else begin
      ready <= go_done;
      err   <= 1'b0;
      unique case (state)
        IDLE: begin
          if (req_ok) begin
            cnt <= CNT_W'(WAIT_CYCLES);
            if (WAIT_CYCLES == 0) begin
              state <= DONE;
            end else begin
              state <= WAIT;
            end
          end else if (req_bad) begin
            err <= 1'b1;
          end
        end
        WAIT: begin
          cnt <= cnt - CNT_W'(1);
          if (cnt == CNT_W'(1)) begin
            state <= DONE;
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  // Request latch; inputs are ignored once the access is accepted.
  always_ff @(posedge clk) begin
    if (idle && req_ok) begin
      op_wr   <= MemWrite;
      idx_q   <= req_idx;
      wdata_q <= wdata;
    end
  end

  data_ram #(
    .DEPTH (DEPTH),
    .IDX_W (IDX_W)
  ) u_ram (
    .clk   (clk),
    .rst   (rst),
    .we    (ram_we),
    .re    (ram_re),
    .idx   (cur_idx),
    .wdata (cur_wdata),
    .rdata (rdata)
  );

endmodule

// File: tb/tb_data_mem_responder.sv
// Bench for data_mem_responder: two instances (2 and 0 wait states),
// cycle-level reference model, directed literal checks, random traffic.
module tb_data_mem_responder;

  logic        clk;
  logic        rs [2];
  logic        rd [2];
  logic        wr [2];
  logic [31:0] ad [2];
  logic [31:0] wd [2];
  logic [31:0] q  [2];
  logic        st [2];
  logic        rdy[2];
  logic        er [2];

  int tests;
  int fails;

  data_mem_responder #(.DEPTH(256), .WAIT_CYCLES(2)) dut (
    .clk(clk), .rst(rs[0]), .MemRead(rd[0]), .MemWrite(wr[0]),
    .addr(ad[0]), .wdata(wd[0]), .rdata(q[0]), .stall(st[0]),
    .ready(rdy[0]), .err(er[0])
  );

  data_mem_responder #(.DEPTH(256), .WAIT_CYCLES(0)) dut0 (
    .clk(clk), .rst(rs[1]), .MemRead(rd[1]), .MemWrite(wr[1]),
    .addr(ad[1]), .wdata(wd[1]), .rdata(q[1]), .stall(st[1]),
    .ready(rdy[1]), .err(er[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  bit [31:0] mmem  [2][256];
  bit        mknown[2][256];
  bit        busy   [2];
  longint    done_at[2];
  bit        m_wr   [2];
  int        m_idx  [2];
  bit [31:0] m_d    [2];
  bit        e_err  [2];
  bit [31:0] e_rd   [2];
  bit        e_rk   [2];
  bit        started[2];
  longint    cyc;

  function automatic int wc(input int c);
    return (c == 0) ? 2 : 0;
  endfunction

  function automatic bit valid_now(input int c);
    return (rd[c] ^ wr[c]) && (ad[c][1:0] == 2'b00);
  endfunction

  function automatic void chk(input string nm, input logic [31:0] got,
                              input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, got, exp, $time);
    end
  endfunction

  // Advance model over the clock edge that ends cycle 'cyc'.
  function automatic void step(input int c);
    bit v;
    v = valid_now(c);
    if (rs[c]) begin
      busy[c]    = 1'b0;
      e_err[c]   = 1'b0;
      e_rd[c]    = '0;
      e_rk[c]    = 1'b1;
      started[c] = 1'b1;
      return;
    end
    e_err[c] = !busy[c] && (rd[c] || wr[c]) && !v;
    if (busy[c] && cyc == done_at[c]) begin
      busy[c] = 1'b0;
    end else if (!busy[c] && v) begin
      busy[c]    = 1'b1;
      done_at[c] = cyc + longint'(wc(c)) + 1;
      m_wr[c]    = wr[c];
      m_idx[c]   = int'(ad[c][9:2]);
      m_d[c]     = wd[c];
    end
    if (busy[c] && cyc == done_at[c] - 1) begin
      if (m_wr[c]) begin
        mmem[c][m_idx[c]]   = m_d[c];
        mknown[c][m_idx[c]] = 1'b1;
      end else begin
        e_rd[c] = mmem[c][m_idx[c]];
        e_rk[c] = mknown[c][m_idx[c]];
      end
    end
  endfunction

  always @(posedge clk) begin
    for (int c = 0; c < 2; c++) step(c);
    cyc++;
  end

  always @(negedge clk) begin
    for (int c = 0; c < 2; c++) begin
      if (started[c]) begin
        logic es;
        logic er_;
        es  = (busy[c] && cyc < done_at[c]) || (!busy[c] && valid_now(c));
        er_ = busy[c] && cyc == done_at[c];
        chk($sformatf("ch%0d stall", c), 32'(st[c]), 32'(es));
        chk($sformatf("ch%0d ready", c), 32'(rdy[c]), 32'(er_));
        chk($sformatf("ch%0d err", c), 32'(er[c]), 32'(e_err[c]));
        if (e_rk[c]) chk($sformatf("ch%0d rdata", c), q[c], e_rd[c]);
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  // Caller is just after a rising edge. Request is held while stalled.
  task automatic access(input int c, input bit r, input bit w,
                        input logic [31:0] a, input logic [31:0] d,
                        output int lat, output bit got_err,
                        output int stall_n, output logic [31:0] rv);
    bit held;
    lat = -1; got_err = 0; stall_n = 0; rv = '0;
    rd[c] = r; wr[c] = w; ad[c] = a; wd[c] = d;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (st[c]) stall_n++;
      if (rdy[c] && lat < 0) lat = k;
      if (er[c]) got_err = 1;
      rv   = q[c];
      held = st[c];
      @(posedge clk); #1;
      if (!held) begin rd[c] = 0; wr[c] = 0; end
      if (lat >= 0 || got_err) break;
    end
    rd[c] = 0; wr[c] = 0;
  endtask

  task automatic do_reset(input int c);
    rs[c] = 1'b1;
    @(posedge clk); #1;
    rs[c] = 1'b0;
  endtask

  int          lat;
  bit          ge;
  int          sn;
  logic [31:0] rv;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int ready_seen;
    tests = 0; fails = 0; cyc = 0;
    for (int c = 0; c < 2; c++) begin
      rs[c] = 1; rd[c] = 0; wr[c] = 0; ad[c] = '0; wd[c] = '0;
    end
    repeat (2) @(posedge clk);
    #1;
    rs[0] = 0; rs[1] = 0;
    @(negedge clk);
    chk("reset rdata", q[0], 32'h0);
    chk("reset stall", 32'(st[0]), 32'h0);
    chk("reset ready", 32'(rdy[0]), 32'h0);
    chk("reset err", 32'(er[0]), 32'h0);
    @(posedge clk); #1;

    // Write then read with two wait states.
    access(0, 0, 1, 32'h10, 32'hDEADBEEF, lat, ge, sn, rv);
    chk("wr10 latency", 32'(lat), 32'd3);
    chk("wr10 stall cycles", 32'(sn), 32'd3);
    access(0, 1, 0, 32'h10, 32'h0, lat, ge, sn, rv);
    chk("rd10 latency", 32'(lat), 32'd3);
    chk("rd10 data", rv, 32'hDEADBEEF);

    // Misaligned read.
    access(0, 1, 0, 32'h13, 32'h0, lat, ge, sn, rv);
    chk("mis err", 32'(ge), 32'd1);
    chk("mis stall cycles", 32'(sn), 32'd0);
    chk("mis rdata held", rv, 32'hDEADBEEF);

    // Both strobes high must not touch the array.
    access(0, 0, 1, 32'h20, 32'hCAFEF00D, lat, ge, sn, rv);
    access(0, 1, 1, 32'h20, 32'h0BADBAD0, lat, ge, sn, rv);
    chk("both err", 32'(ge), 32'd1);
    access(0, 1, 0, 32'h20, 32'h0, lat, ge, sn, rv);
    chk("both keep", rv, 32'hCAFEF00D);

    // Address wrap.
    access(0, 0, 1, 32'h400, 32'h12345678, lat, ge, sn, rv);
    access(0, 1, 0, 32'h0, 32'h0, lat, ge, sn, rv);
    chk("wrap data", rv, 32'h12345678);

    // Reset during the first wait cycle abandons the write.
    access(0, 0, 1, 32'h8, 32'h11111111, lat, ge, sn, rv);
    rd[0] = 0; wr[0] = 1; ad[0] = 32'h8; wd[0] = 32'hA5A5A5A5;
    @(negedge clk);
    chk("abort req stall", 32'(st[0]), 32'd1);
    @(posedge clk); #1;
    wr[0] = 0; rs[0] = 1;
    @(negedge clk);
    @(posedge clk); #1;
    rs[0] = 0;
    ready_seen = 0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      if (rdy[0] || st[0]) ready_seen++;
      if (k == 0) chk("abort rdata cleared", q[0], 32'h0);
    end
    chk("abort no ready", 32'(ready_seen), 32'd0);
    @(posedge clk); #1;
    access(0, 1, 0, 32'h8, 32'h0, lat, ge, sn, rv);
    chk("abort old data", rv, 32'h11111111);

    // Zero wait states, back-to-back reads.
    access(1, 0, 1, 32'h4, 32'hAAAA0004, lat, ge, sn, rv);
    chk("ws0 wr latency", 32'(lat), 32'd1);
    access(1, 0, 1, 32'h8, 32'hBBBB0008, lat, ge, sn, rv);
    access(1, 1, 0, 32'h4, 32'h0, lat, ge, sn, rv);
    chk("ws0 rd4 latency", 32'(lat), 32'd1);
    chk("ws0 rd4 stall", 32'(sn), 32'd1);
    chk("ws0 rd4 data", rv, 32'hAAAA0004);
    access(1, 1, 0, 32'h8, 32'h0, lat, ge, sn, rv);
    chk("ws0 rd8 latency", 32'(lat), 32'd1);
    chk("ws0 rd8 data", rv, 32'hBBBB0008);

    // Random traffic checked by the model.
    for (int c = 0; c < 2; c++) begin
      for (int n = 0; n < 200; n++) begin
        int          kind;
        bit          r;
        bit          w;
        logic [31:0] a;
        logic [31:0] d;
        kind = int'($urandom_range(0, 15));
        if (kind == 0) begin
          do_reset(c);
        end else if (kind < 3) begin
          @(posedge clk); #1;
        end else begin
          r = 1'($urandom_range(0, 1));
          w = !r;
          if (kind == 3) begin r = 1; w = 1; end
          a = $urandom;
          a[9:2] = 8'($urandom_range(0, 15));
          a[1:0] = (kind == 4) ? 2'($urandom_range(1, 3)) : 2'b00;
          d = $urandom;
          access(c, r, w, a, d, lat, ge, sn, rv);
        end
      end
    end

    repeat (3) @(posedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
